// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Shared opcode encodings and arbiter state type for the add/sub alu.
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module : alu
// Brief  : Combinational add/subtract unit; result wraps modulo 2^DATA_WIDTH.
// Rev    : 1.0  initial release
// ============================================================================
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_op,
  output logic [DATA_WIDTH-1:0] o_result
);

  always_comb begin
    o_result = '0;
    if (i_op == ALU_SUB) begin
      o_result = i_a - i_b;
    end else begin
      o_result = i_a + i_b;
    end
  end

endmodule : alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_arbiter
// Brief  : Round-robin sharing of one add/sub alu among NUM_REQ requesters,
//          with a registered, held-until-accepted result and flags.
// Rev    : 1.0  initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_A_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_B_in,
  input  logic [NUM_REQ-1:0]            req_op_in,
  output logic                          resp_valid_out,
  input  logic                          resp_ready_in,
  output logic [DATA_WIDTH-1:0]         resp_data_out,
  output logic                          resp_zero_out,
  output logic                          resp_signal_out,
  output logic [ID_W-1:0]               resp_id_out
);

  // First valid requester at or after the pointer, wrapping past NUM_REQ-1.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    return pick;
  endfunction

  arb_state_t              r_state;
  arb_state_t              w_state_next;
  logic [ID_W-1:0]         r_ptr;
  logic [DATA_WIDTH-1:0]   r_op_a;
  logic [DATA_WIDTH-1:0]   r_op_b;
  logic                    r_op;
  logic [ID_W-1:0]         r_id;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_data;
  logic                    r_resp_zero;
  logic                    r_resp_sign;
  logic [ID_W-1:0]         r_resp_id;

  logic                    w_can_accept;
  logic                    w_grant_en;
  logic [ID_W-1:0]         w_grant;
  logic [ID_W-1:0]         w_ptr_next;
  logic [DATA_WIDTH-1:0]   w_alu_result;

  // A new grant is possible when idle, or when the held result is consumed this cycle.
  assign w_can_accept = !reset_in &&
                        ((r_state == ARB_IDLE) || ((r_state == ARB_RESP) && resp_ready_in));
  assign w_grant_en   = w_can_accept && (|req_valid_in);
  assign w_grant      = rr_pick(req_valid_in, r_ptr);
  assign w_ptr_next   = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + ID_W'(1);

  assign req_ready_out   = w_grant_en ? (NUM_REQ'(1) << w_grant) : '0;
  assign resp_valid_out  = r_resp_valid;
  assign resp_data_out   = r_resp_data;
  assign resp_zero_out   = r_resp_zero;
  assign resp_signal_out = r_resp_sign;
  assign resp_id_out     = r_resp_id;

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .i_op     (r_op),
    .o_result (w_alu_result)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_en) begin
          w_state_next = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        w_state_next = ARB_RESP;
      end
      ARB_RESP: begin
        if (resp_ready_in) begin
          w_state_next = w_grant_en ? ARB_EXEC : ARB_IDLE;
        end
      end
      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_ptr        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op         <= ALU_ADD;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_zero  <= 1'b0;
      r_resp_sign  <= 1'b0;
      r_resp_id    <= '0;
    end else begin
      if (w_grant_en) begin
        r_op_a <= req_A_in[w_grant*DATA_WIDTH +: DATA_WIDTH];
        r_op_b <= req_B_in[w_grant*DATA_WIDTH +: DATA_WIDTH];
        r_op   <= req_op_in[w_grant];
        r_id   <= w_grant;
        r_ptr  <= w_ptr_next;
      end
      // Flags come from the same result being registered, so they can never lag the data.
      if (r_state == ARB_EXEC) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_alu_result;
        r_resp_zero  <= (w_alu_result == '0);
        r_resp_sign  <= w_alu_result[DATA_WIDTH-1];
        r_resp_id    <= r_id;
      end else if ((r_state == ARB_RESP) && resp_ready_in) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

endmodule : alu_arbiter
`default_nettype wire
